// File: rtl/light_pen_locator.sv
// -----------------------------------------------------------------------------
// light_pen_locator
//
// Works out which LED-matrix pixel a light pen is pointing at. It watches the
// same one-hot row/column scan that drives the display and the raw photodiode
// level. A position is accepted once it has been hit in CONFIRM_FRAMES
// consecutive frames. While locked, every new pixel is reported straight away,
// so a stroke can be drawn. The lock is dropped after MISS_FRAMES consecutive
// frames with no hit at all.
//
// Parameters:
//   PEN_DELAY      (0..15) cycles the scan address is delayed so that it lines
//                  up with the synchronized pen level
//   CONFIRM_FRAMES (1..15) consecutive same-pixel frames needed to lock
//   MISS_FRAMES    (1..15) consecutive empty frames that drop the lock
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   scan_row   in   [7:0] one-hot active row of the current scan pixel
//   scan_col   in   [7:0] one-hot active column of the current scan pixel
//   pen_in     in   raw photodiode level, asynchronous, high = light seen
//   pen_valid  out  pen is locked on the matrix
//   pen_row    out  [2:0] binary row of the locked position
//   pen_col    out  [2:0] binary column of the locked position
//   pen_we     out  one-cycle strobe: a new position has been accepted
// -----------------------------------------------------------------------------
module light_pen_locator #(
  parameter int PEN_DELAY      = 2,
  parameter int CONFIRM_FRAMES = 2,
  parameter int MISS_FRAMES    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  input  logic       pen_in,
  output logic       pen_valid,
  output logic [2:0] pen_row,
  output logic [2:0] pen_col,
  output logic       pen_we
);

  localparam logic [3:0] CONF_TH = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] MISS_TH = 4'(MISS_FRAMES);
  localparam logic [3:0] CNT_MAX = 4'd15;

  typedef enum logic {
    ST_SEEK = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Pen synchronizer
  // ---------------------------------------------------------------------------
  logic pen_meta_q;
  logic pen_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pen_meta_q <= 1'b0;
      pen_s_q    <= 1'b0;
    end else begin
      pen_meta_q <= pen_in;
      pen_s_q    <= pen_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // One-hot to binary address encode
  // ---------------------------------------------------------------------------
  logic       row_ok;
  logic       col_ok;
  logic       addr_ok;
  logic [2:0] row_bin;
  logic [2:0] col_bin;
  logic [6:0] addr_raw;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign row_ok  = (scan_row != 8'd0) && ((scan_row & (scan_row - 8'd1)) == 8'd0);
  assign col_ok  = (scan_col != 8'd0) && ((scan_col & (scan_col - 8'd1)) == 8'd0);
  assign addr_ok = row_ok && col_ok;

  // Each binary bit is the OR of the one-hot positions whose index has it set.
  // The result is only meaningful when the input is one-hot.
  assign row_bin = {|(scan_row & 8'hF0), |(scan_row & 8'hCC), |(scan_row & 8'hAA)};
  assign col_bin = {|(scan_col & 8'hF0), |(scan_col & 8'hCC), |(scan_col & 8'hAA)};

  assign addr_raw = {addr_ok, row_bin, col_bin};

  // ---------------------------------------------------------------------------
  // Scan address delay line
  // ---------------------------------------------------------------------------
  logic [6:0] addr_dly;

  generate
    if (PEN_DELAY == 0) begin : g_no_dly
      assign addr_dly = addr_raw;
    end else begin : g_dly
      logic [PEN_DELAY-1:0][6:0] dly_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= addr_raw;
          for (int i = 1; i < PEN_DELAY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign addr_dly = dly_q[PEN_DELAY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame boundary detect and hit qualification
  // ---------------------------------------------------------------------------
  logic       d_ok;
  logic [5:0] d_addr;
  logic       d_zero;
  logic       boundary;
  logic       pen_hit;
  logic       prev_zero_q;
  logic       prev_zero_d;

  assign d_ok   = addr_dly[6];
  assign d_addr = addr_dly[5:0];
  assign d_zero = d_ok && (d_addr == 6'd0);

  // Pixel (0,0) lasts several cycles; only its first cycle starts a frame.
  assign boundary    = d_zero && !prev_zero_q;
  assign prev_zero_d = d_zero;
  assign pen_hit     = pen_s_q && d_ok;

  // ---------------------------------------------------------------------------
  // Tracking state
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [5:0] cand_q, cand_d;
  logic [3:0] conf_q, conf_d;
  logic [3:0] miss_q, miss_d;
  logic       hit_flag_q, hit_flag_d;
  logic [5:0] hit_addr_q, hit_addr_d;
  logic       pen_valid_q, pen_valid_d;
  logic [5:0] pen_pos_q, pen_pos_d;
  logic       pen_we_q, pen_we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEEK;
      cand_q      <= 6'd0;
      conf_q      <= 4'd0;
      miss_q      <= 4'd0;
      hit_flag_q  <= 1'b0;
      hit_addr_q  <= 6'd0;
      prev_zero_q <= 1'b0;
      pen_valid_q <= 1'b0;
      pen_pos_q   <= 6'd0;
      pen_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      conf_q      <= conf_d;
      miss_q      <= miss_d;
      hit_flag_q  <= hit_flag_d;
      hit_addr_q  <= hit_addr_d;
      prev_zero_q <= prev_zero_d;
      pen_valid_q <= pen_valid_d;
      pen_pos_q   <= pen_pos_d;
      pen_we_q    <= pen_we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit capture: the first qualified hit of a frame wins. On a boundary the
  // registered hit still describes the finished frame (used by the FSM below)
  // while the capture restarts for the new frame, including this very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit_flag_d = hit_flag_q;
    hit_addr_d = hit_addr_q;
    if (boundary) begin
      hit_flag_d = pen_hit;
      if (pen_hit) begin
        hit_addr_d = d_addr;
      end
    end else if (pen_hit && !hit_flag_q) begin
      hit_flag_d = 1'b1;
      hit_addr_d = d_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM, advanced once per frame boundary
  // ---------------------------------------------------------------------------
  logic [3:0] conf_nxt;
  logic [3:0] miss_nxt;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    conf_d      = conf_q;
    miss_d      = miss_q;
    pen_valid_d = pen_valid_q;
    pen_pos_d   = pen_pos_q;
    pen_we_d    = 1'b0;
    conf_nxt    = conf_q;
    miss_nxt    = miss_q;

    if (boundary) begin
      unique case (state_q)
        ST_SEEK: begin
          if (hit_flag_q) begin
            if (hit_addr_q == cand_q) begin
              conf_nxt = (conf_q == CNT_MAX) ? conf_q : conf_q + 4'd1;
            end else begin
              cand_d   = hit_addr_q;
              conf_nxt = 4'd1;
            end
          end else begin
            conf_nxt = 4'd0;
          end
          conf_d = conf_nxt;
          if (conf_nxt >= CONF_TH) begin
            state_d     = ST_LOCK;
            pen_valid_d = 1'b1;
            pen_pos_d   = cand_d;
            pen_we_d    = 1'b1;
            miss_d      = 4'd0;
          end
        end

        ST_LOCK: begin
          if (hit_flag_q) begin
            miss_d = 4'd0;
            // A new pixel while locked is a pen stroke: report it at once.
            if (hit_addr_q != pen_pos_q) begin
              pen_pos_d = hit_addr_q;
              pen_we_d  = 1'b1;
            end
          end else begin
            miss_nxt = (miss_q == CNT_MAX) ? miss_q : miss_q + 4'd1;
            miss_d   = miss_nxt;
            if (miss_nxt >= MISS_TH) begin
              // Coordinates deliberately keep the last locked position.
              state_d     = ST_SEEK;
              pen_valid_d = 1'b0;
              conf_d      = 4'd0;
            end
          end
        end

        default: begin
          state_d = ST_SEEK;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from registers
  // ---------------------------------------------------------------------------
  assign pen_valid = pen_valid_q;
  assign pen_row   = pen_pos_q[5:3];
  assign pen_col   = pen_pos_q[2:0];
  assign pen_we    = pen_we_q;

endmodule

// File: tb/tb_light_pen_locator.sv
// -----------------------------------------------------------------------------
// tb_light_pen_locator
//
// Directed bench for light_pen_locator with the default parameters
// (PEN_DELAY = 2, CONFIRM_FRAMES = 2, MISS_FRAMES = 4). Frames are 64 pixels
// scanned in row-major order, 4 cycles per pixel. Each frame call returns
// what was seen during that frame. The boundary that evaluates the previous
// frame shows its outputs at frame cycle 3.
// -----------------------------------------------------------------------------
module tb_light_pen_locator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scan_row;
  logic [7:0] scan_col;
  logic       pen_in;
  logic       pen_valid;
  logic [2:0] pen_row;
  logic [2:0] pen_col;
  logic       pen_we;

  light_pen_locator #(
    .PEN_DELAY     (2),
    .CONFIRM_FRAMES(2),
    .MISS_FRAMES   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_row (scan_row),
    .scan_col (scan_col),
    .pen_in   (pen_in),
    .pen_valid(pen_valid),
    .pen_row  (pen_row),
    .pen_col  (pen_col),
    .pen_we   (pen_we)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Results of the most recent frame call
  int         res_we_cnt;
  logic [2:0] res_we_row;
  logic [2:0] res_we_col;
  logic       res_v2;
  logic       res_v3;
  logic [2:0] res_r3;
  logic [2:0] res_c3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full frame. (ar,ac) and (br,bc) are pixels with the pen high;
  // (xr,xc) is a pixel scanned with a two-hot column while the pen is high;
  // rst_at is the frame cycle where reset is pulsed (-1 for none).
  task automatic run_frame(input string name, input int ar, input int ac,
                           input int br, input int bc, input int xr, input int xc,
                           input int rst_at);
    res_we_cnt = 0;
    res_we_row = 3'd0;
    res_we_col = 3'd0;
    res_v2     = 1'b0;
    res_v3     = 1'b0;
    res_r3     = 3'd0;
    res_c3     = 3'd0;
    for (int k = 0; k < 256; k++) begin
      int p;
      int r;
      int c;
      p = k / 4;
      r = p / 8;
      c = p % 8;
      @(negedge clk);
      if (pen_we === 1'b1) begin
        res_we_cnt++;
        res_we_row = pen_row;
        res_we_col = pen_col;
      end
      if (k == 2) res_v2 = pen_valid;
      if (k == 3) begin
        res_v3 = pen_valid;
        res_r3 = pen_row;
        res_c3 = pen_col;
      end
      scan_row = 8'(1 << r);
      scan_col = 8'(1 << c);
      pen_in   = ((r == ar) && (c == ac)) || ((r == br) && (c == bc));
      if ((r == xr) && (c == xc)) begin
        scan_col = 8'h03;
        pen_in   = 1'b1;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_eq({name, "_async_valid"}, 32'(pen_valid), 32'd0);
        check_eq({name, "_async_row"},   32'(pen_row),   32'd0);
        check_eq({name, "_async_col"},   32'(pen_col),   32'd0);
        check_eq({name, "_async_we"},    32'(pen_we),    32'd0);
      end
      if ((rst_at >= 0) && (k == rst_at + 6)) rst_n = 1'b1;
    end
    $display("frame %s: we_cnt=%0d we_pos=(%0d,%0d) valid@3=%0b pos@3=(%0d,%0d)",
             name, res_we_cnt, res_we_row, res_we_col, res_v3, res_r3, res_c3);
  endtask

  task automatic hit(input string name, input int r, input int c);
    run_frame(name, r, c, -1, -1, -1, -1, -1);
  endtask

  task automatic idle(input string name);
    run_frame(name, -1, -1, -1, -1, -1, -1, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_n    = 1'b1;
    scan_row = 8'd0;
    scan_col = 8'd0;
    pen_in   = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("reset_valid", 32'(pen_valid), 32'd0);
    check_eq("reset_row",   32'(pen_row),   32'd0);
    check_eq("reset_col",   32'(pen_col),   32'd0);
    check_eq("reset_we",    32'(pen_we),    32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Acquire lock at (3,5)
    hit("f0", 3, 5);
    check_eq("f0_we", 32'(res_we_cnt), 32'd0);
    hit("f1", 3, 5);
    check_eq("acq1_valid", 32'(res_v3), 32'd0);
    check_eq("acq1_we",    32'(res_we_cnt), 32'd0);
    hit("f2", 3, 5);
    check_eq("acq_valid_early", 32'(res_v2), 32'd0);
    check_eq("acq_valid",  32'(res_v3), 32'd1);
    check_eq("acq_row",    32'(res_r3), 32'd3);
    check_eq("acq_col",    32'(res_c3), 32'd5);
    check_eq("acq_we_cnt", 32'(res_we_cnt), 32'd1);
    check_eq("acq_we_row", 32'(res_we_row), 32'd3);
    check_eq("acq_we_col", 32'(res_we_col), 32'd5);

    // Same pixel again: no strobe. Then move while locked.
    hit("f3", 4, 5);
    check_eq("same_we",    32'(res_we_cnt), 32'd0);
    check_eq("same_valid", 32'(res_v3), 32'd1);
    hit("f4", 4, 6);
    check_eq("move1_we",   32'(res_we_cnt), 32'd1);
    check_eq("move1_row",  32'(res_we_row), 32'd4);
    check_eq("move1_col",  32'(res_we_col), 32'd5);
    idle("f5");
    check_eq("move2_we",   32'(res_we_cnt), 32'd1);
    check_eq("move2_row",  32'(res_we_row), 32'd4);
    check_eq("move2_col",  32'(res_we_col), 32'd6);

    // Three empty frames, then a hit: lock survives
    idle("f6");
    idle("f7");
    hit("f8", 4, 6);
    check_eq("miss3_valid", 32'(res_v3), 32'd1);
    idle("f9");
    check_eq("keep_valid", 32'(res_v3), 32'd1);
    check_eq("keep_we",    32'(res_we_cnt), 32'd0);

    // Four empty frames: lock drops, coordinates hold
    idle("f10");
    idle("f11");
    idle("f12");
    check_eq("miss3b_valid", 32'(res_v3), 32'd1);
    idle("f13");
    check_eq("drop_valid", 32'(res_v3), 32'd0);
    check_eq("drop_row",   32'(res_r3), 32'd4);
    check_eq("drop_col",   32'(res_c3), 32'd6);
    check_eq("drop_we",    32'(res_we_cnt), 32'd0);

    // Two hits per frame: first one in scan order wins
    run_frame("f14", 1, 1, 6, 6, -1, -1, -1);
    run_frame("f15", 1, 1, 6, 6, -1, -1, -1);
    check_eq("multi1_valid", 32'(res_v3), 32'd0);
    idle("f16");
    check_eq("multi_valid", 32'(res_v3), 32'd1);
    check_eq("multi_row",   32'(res_r3), 32'd1);
    check_eq("multi_col",   32'(res_c3), 32'd1);
    check_eq("multi_we",    32'(res_we_cnt), 32'd1);
    idle("f17");
    idle("f18");
    idle("f19");

    // Two-hot column while the pen is high: nothing recorded
    run_frame("f20", -1, -1, -1, -1, 2, 3, -1);
    check_eq("drop2_valid", 32'(res_v3), 32'd0);
    run_frame("f21", -1, -1, -1, -1, 2, 3, -1);
    hit("f22", 2, 2);
    check_eq("bad_valid", 32'(res_v3), 32'd0);
    check_eq("bad_we",    32'(res_we_cnt), 32'd0);

    // Alternating pixels never confirm
    hit("f23", 5, 5);
    hit("f24", 2, 2);
    check_eq("alt1_valid", 32'(res_v3), 32'd0);
    hit("f25", 5, 5);
    check_eq("alt2_valid", 32'(res_v3), 32'd0);
    hit("f26", 5, 5);
    check_eq("alt3_valid", 32'(res_v3), 32'd0);
    check_eq("alt3_we",    32'(res_we_cnt), 32'd0);

    // Lock at (5,5), then reset in the middle of the frame
    run_frame("f27", -1, -1, -1, -1, -1, -1, 100);
    check_eq("prerst_valid", 32'(res_v3), 32'd1);
    check_eq("prerst_row",   32'(res_r3), 32'd5);
    check_eq("prerst_col",   32'(res_c3), 32'd5);

    // Re-lock takes two full frames after release
    hit("f28", 3, 5);
    check_eq("postrst_valid", 32'(res_v3), 32'd0);
    hit("f29", 3, 5);
    check_eq("relock1_valid", 32'(res_v3), 32'd0);
    idle("f30");
    check_eq("relock_valid", 32'(res_v3), 32'd1);
    check_eq("relock_row",   32'(res_r3), 32'd3);
    check_eq("relock_col",   32'(res_c3), 32'd5);
    check_eq("relock_we",    32'(res_we_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
